// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer: FSM state encoding,
// PC select codes and the instruction-alignment helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_FETCH  = 2'b01,
    ST_HOLD   = 2'b10,
    ST_HALTED = 2'b11
  } fetch_state_e;

  localparam logic PC_SEL_INC  = 1'b0;
  localparam logic PC_SEL_LOAD = 1'b1;

  localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return |(addr & ALIGN_MASK);
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Counts consecutive stalled fetch cycles and flags the cycle in which the
// stall reaches TIMEOUT_CYCLES. TIMEOUT_CYCLES=0 disables the watchdog.
module fetch_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic enable_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam logic [TO_W-1:0] LAST_COUNT = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) count_q <= '0;
    else          count_q <= count_d;
  end

  // The current stalled cycle is counted as well, so expiry fires on stall number TIMEOUT_CYCLES.
  assign expired_o = (TIMEOUT_CYCLES != 0) && enable_i && (count_q == LAST_COUNT);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch control for the single-cycle core: steers program_counter, runs the imem
// req/ack handshake and buffers one instruction for decode.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic        Clk_Core,
  input  logic        Rst_Core_N,
  input  logic [31:0] Program_Count,
  output logic        PC_Sel,
  output logic [31:0] Program_Count_Imm,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic        Imem_Ack,
  input  logic [31:0] Imem_Rdata,
  output logic        Instr_Valid,
  output logic [31:0] Instr,
  output logic [31:0] Instr_PC,
  input  logic        Instr_Ready,
  input  logic        Redirect_Valid,
  input  logic [31:0] Redirect_Target,
  input  logic        Halt,
  output logic        Halted,
  output logic        Fault
);

  fetch_state_e state_q, state_d;
  logic         redir_pend_q, redir_pend_d;
  logic [31:0]  redir_tgt_q, redir_tgt_d;
  logic         halt_pend_q, halt_pend_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         fault_q, fault_d;
  logic         wd_enable, wd_expired, redir_bad;

  assign wd_enable = (state_q == ST_FETCH) && !Imem_Ack;

  fetch_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_watchdog (
    .clk_i    (Clk_Core),
    .rst_n_i  (Rst_Core_N),
    .enable_i (wd_enable),
    .clear_i  (!wd_enable),
    .expired_o(wd_expired)
  );

  assign redir_bad = Redirect_Valid && is_misaligned(Redirect_Target);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d           = state_q;
    redir_pend_d      = redir_pend_q;
    redir_tgt_d       = redir_tgt_q;
    halt_pend_d       = halt_pend_q;
    instr_d           = instr_q;
    instr_pc_d        = instr_pc_q;
    fault_d           = fault_q;
    PC_Sel            = PC_SEL_LOAD;
    Program_Count_Imm = Program_Count;

    unique case (state_q)
      ST_IDLE: state_d = Halt ? ST_HALTED : ST_FETCH;

      ST_FETCH: begin
        if (Halt) halt_pend_d = 1'b1;
        if (redir_bad) begin
          fault_d      = 1'b1;
          redir_pend_d = 1'b0;
          state_d      = ST_HALTED;
        end else if (Imem_Ack) begin
          if (Redirect_Valid || redir_pend_q) begin
            // A redirect seen during this fetch makes the returned word stale; restart at the newest target.
            Program_Count_Imm = Redirect_Valid ? Redirect_Target : redir_tgt_q;
            redir_pend_d      = 1'b0;
          end else begin
            instr_d    = Imem_Rdata;
            instr_pc_d = Program_Count;
            state_d    = ST_HOLD;
          end
        end else if (wd_expired) begin
          fault_d = 1'b1;
          state_d = ST_HALTED;
        end else if (Redirect_Valid) begin
          redir_pend_d = 1'b1;
          redir_tgt_d  = Redirect_Target;
        end
      end

      ST_HOLD: begin
        if (Halt) halt_pend_d = 1'b1;
        if (redir_bad) begin
          fault_d = 1'b1;
          state_d = ST_HALTED;
        end else if (Redirect_Valid) begin
          Program_Count_Imm = Redirect_Target;
          state_d           = ST_FETCH;
        end else if (Instr_Ready) begin
          PC_Sel  = PC_SEL_INC;
          state_d = (Halt || halt_pend_q) ? ST_HALTED : ST_FETCH;
        end
      end

      ST_HALTED: ;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk_Core) begin
    if (!Rst_Core_N) begin
      state_q      <= ST_IDLE;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= '0;
      halt_pend_q  <= 1'b0;
      instr_q      <= '0;
      instr_pc_q   <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      redir_pend_q <= redir_pend_d;
      redir_tgt_q  <= redir_tgt_d;
      halt_pend_q  <= halt_pend_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      fault_q      <= fault_d;
    end
  end

  assign Imem_Req    = (state_q == ST_FETCH);
  assign Imem_Addr   = Program_Count;
  assign Instr_Valid = (state_q == ST_HOLD);
  assign Instr       = instr_q;
  assign Instr_PC    = instr_pc_q;
  assign Halted      = (state_q == ST_HALTED);
  assign Fault       = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural program_counter and
// an instruction memory whose word is a fixed function of its address.
module tb_fetch_sequencer;

  localparam logic [31:0] MAGIC = 32'h1357_9BDF;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_q;
  logic        pc_sel;
  logic [31:0] pc_imm;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt;
  logic        halted;
  logic        fault;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_sequencer #(
    .TIMEOUT_CYCLES(4),
    .TO_W          (8)
  ) dut (
    .Clk_Core         (clk),
    .Rst_Core_N       (rst_n),
    .Program_Count    (pc_q),
    .PC_Sel           (pc_sel),
    .Program_Count_Imm(pc_imm),
    .Imem_Req         (imem_req),
    .Imem_Addr        (imem_addr),
    .Imem_Ack         (imem_ack),
    .Imem_Rdata       (imem_rdata),
    .Instr_Valid      (instr_valid),
    .Instr            (instr),
    .Instr_PC         (instr_pc),
    .Instr_Ready      (instr_ready),
    .Redirect_Valid   (redirect_valid),
    .Redirect_Target  (redirect_target),
    .Halt             (halt),
    .Halted           (halted),
    .Fault            (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // program_counter model: load on PC_Sel=1, otherwise +4.
  always @(posedge clk) begin
    if (!rst_n)      pc_q <= 32'h0;
    else if (pc_sel) pc_q <= pc_imm;
    else             pc_q <= pc_q + 32'd4;
  end

  assign imem_rdata = imem_addr ^ MAGIC;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    imem_ack        = 1'b0;
    instr_ready     = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    halt            = 1'b0;
  endtask

  // Leaves the DUT in its first FETCH cycle with PC=0.
  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    step();
    step();
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h want 0", instr); end
    n_checks++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL rst_instr_pc: got %h want 0", instr_pc); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b want 0", halted); end
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b want 0", fault); end
    n_checks++; if (pc_sel !== 1'b1) begin n_fail++; $display("FAIL rst_pc_sel: got %b want 1", pc_sel); end
    n_checks++; if (pc_imm !== 32'h0) begin n_fail++; $display("FAIL rst_pc_imm: got %h want 0", pc_imm); end
    rst_n = 1'b1;
    step();
    #1;
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL idle_to_fetch: got %b want 1", imem_req); end
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    do_reset();
    imem_ack    = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = 32'(i) * 32'd4;
      #1;
      n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL seq_req[%0d]: got %b want 1", i, imem_req); end
      n_checks++; if (imem_addr !== a) begin n_fail++; $display("FAIL seq_addr[%0d]: got %h want %h", i, imem_addr, a); end
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL seq_gap[%0d]: got %b want 0", i, instr_valid); end
      step();
      #1;
      n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d]: got %b want 1", i, instr_valid); end
      n_checks++; if (instr_pc !== a) begin n_fail++; $display("FAIL seq_instr_pc[%0d]: got %h want %h", i, instr_pc, a); end
      n_checks++; if (instr !== (a ^ MAGIC)) begin n_fail++; $display("FAIL seq_instr[%0d]: got %h want %h", i, instr, a ^ MAGIC); end
      n_checks++; if (pc_sel !== 1'b0) begin n_fail++; $display("FAIL seq_inc[%0d]: got %b want 0", i, pc_sel); end
      step();
    end
  endtask

  task automatic test_hold_stall();
    do_reset();
    imem_ack    = 1'b1;
    instr_ready = 1'b1;
    step();
    step();
    step();
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (pc_q !== 32'h4) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h want 4", k, pc_q); end
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req[%0d]: got %b want 0", k, imem_req); end
      n_checks++; if (instr !== (32'h4 ^ MAGIC)) begin n_fail++; $display("FAIL stall_instr[%0d]: got %h want %h", k, instr, 32'h4 ^ MAGIC); end
      n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", k, instr_valid); end
      step();
    end
    instr_ready = 1'b1;
    #1;
    n_checks++; if (pc_sel !== 1'b0) begin n_fail++; $display("FAIL stall_release: got %b want 0", pc_sel); end
    step();
    #1;
    n_checks++; if (pc_q !== 32'h8) begin n_fail++; $display("FAIL stall_next_pc: got %h want 8", pc_q); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stall_consumed: got %b want 0", instr_valid); end
  endtask

  task automatic test_redirect_fetch();
    do_reset();
    redirect_valid  = 1'b1;
    redirect_target = 32'h100;
    #1;
    n_checks++; if (pc_sel !== 1'b1 || pc_imm !== 32'h0) begin n_fail++; $display("FAIL rf_capture_hold: got sel=%b imm=%h want sel=1 imm=0", pc_sel, pc_imm); end
    step();
    redirect_valid = 1'b0;
    step();
    imem_ack = 1'b1;
    #1;
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rf_old_addr: got %h want 0", imem_addr); end
    n_checks++; if (pc_sel !== 1'b1 || pc_imm !== 32'h100) begin n_fail++; $display("FAIL rf_load: got sel=%b imm=%h want sel=1 imm=100", pc_sel, pc_imm); end
    step();
    #1;
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rf_dropped: got %b want 0", instr_valid); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL rf_new_addr: got req=%b addr=%h want req=1 addr=100", imem_req, imem_addr); end
    step();
    #1;
    n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL rf_valid: got %b want 1", instr_valid); end
    n_checks++; if (instr_pc !== 32'h100) begin n_fail++; $display("FAIL rf_instr_pc: got %h want 100", instr_pc); end
    n_checks++; if (instr !== (32'h100 ^ MAGIC)) begin n_fail++; $display("FAIL rf_instr: got %h want %h", instr, 32'h100 ^ MAGIC); end
  endtask

  task automatic test_redirect_accept();
    do_reset();
    imem_ack    = 1'b1;
    instr_ready = 1'b1;
    step();
    redirect_valid  = 1'b1;
    redirect_target = 32'h200;
    #1;
    n_checks++; if (pc_sel !== 1'b1 || pc_imm !== 32'h200) begin n_fail++; $display("FAIL ra_load: got sel=%b imm=%h want sel=1 imm=200", pc_sel, pc_imm); end
    step();
    redirect_valid = 1'b0;
    #1;
    n_checks++; if (pc_q !== 32'h200) begin n_fail++; $display("FAIL ra_pc: got %h want 200", pc_q); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL ra_valid: got %b want 0", instr_valid); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL ra_fetch: got req=%b addr=%h want req=1 addr=200", imem_req, imem_addr); end
    step();
    #1;
    n_checks++; if (instr_pc !== 32'h200) begin n_fail++; $display("FAIL ra_instr_pc: got %h want 200", instr_pc); end
  endtask

  task automatic test_misaligned();
    do_reset();
    imem_ack = 1'b1;
    step();
    imem_ack        = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h102;
    #1;
    n_checks++; if (pc_sel !== 1'b1 || pc_imm !== 32'h0) begin n_fail++; $display("FAIL mis_no_load: got sel=%b imm=%h want sel=1 imm=0", pc_sel, pc_imm); end
    step();
    redirect_valid = 1'b0;
    #1;
    n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL mis_fault: got %b want 1", fault); end
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL mis_halted: got %b want 1", halted); end
    n_checks++; if (pc_q !== 32'h0) begin n_fail++; $display("FAIL mis_pc: got %h want 0", pc_q); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL mis_valid: got %b want 0", instr_valid); end
    step();
    step();
    #1;
    n_checks++; if (imem_req !== 1'b0 || pc_q !== 32'h0) begin n_fail++; $display("FAIL mis_stays: got req=%b pc=%h want req=0 pc=0", imem_req, pc_q); end
  endtask

  task automatic test_halt();
    do_reset();
    halt = 1'b1;
    step();
    halt     = 1'b0;
    imem_ack = 1'b1;
    step();
    #1;
    n_checks++; if (instr_valid !== 1'b1 || halted !== 1'b0) begin n_fail++; $display("FAIL halt_deliver: got valid=%b halted=%b want valid=1 halted=0", instr_valid, halted); end
    instr_ready = 1'b1;
    step();
    #1;
    n_checks++; if (halted !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL halt_stop: got halted=%b req=%b want halted=1 req=0", halted, imem_req); end
    n_checks++; if (pc_q !== 32'h4 || fault !== 1'b0) begin n_fail++; $display("FAIL halt_pc: got pc=%h fault=%b want pc=4 fault=0", pc_q, fault); end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      step();
      #1;
      n_checks++; if (fault !== 1'b0 || imem_req !== 1'b1) begin n_fail++; $display("FAIL to_early[%0d]: got fault=%b req=%b want fault=0 req=1", k, fault, imem_req); end
    end
    step();
    #1;
    n_checks++; if (fault !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL to_fire: got fault=%b halted=%b req=%b want 1 1 0", fault, halted, imem_req); end
    // Reset while a fetch is outstanding, then a stray ack during IDLE.
    do_reset();
    step();
    rst_n = 1'b0;
    step();
    #1;
    n_checks++; if (imem_req !== 1'b0 || fault !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL to_reset: got req=%b fault=%b valid=%b want 0 0 0", imem_req, fault, instr_valid); end
    rst_n    = 1'b1;
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL to_stray_ack: got req=%b valid=%b want req=1 valid=0", imem_req, instr_valid); end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_sequential();
    test_hold_stall();
    test_redirect_fetch();
    test_redirect_accept();
    test_misaligned();
    test_halt();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
